// File: rtl/nubus_arb_pkg.sv
// Shared types and constants for the NuBus master arbiter.
//   arb_state_e : arbiter FSM states
//   ADDR_W, DATA_W, BE_W : width of one requester's address, data and
//                          byte-enable slice on the flattened request buses
package nubus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT  = 2'd1,
      ARB_GAP    = 2'd2,
      ARB_LOCKED = 2'd3
   } arb_state_e;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

endpackage

// File: rtl/nubus_rr_picker.sv
// Combinational round-robin priority select.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1 and wraps
//   grant : one-hot winner (0 when no request)
//   idx   : binary index of the winner
//   any   : at least one request present
module nubus_rr_picker #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic             found;
   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      idx      = '0;
      grant    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand     = (int'(ptr) + 1 + k) % NREQ;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
      if (found) grant[idx] = 1'b1;
   end

   assign any = |req;

endmodule

// File: rtl/nubus_master_arbiter.sv
// Shares the NuBus master (cpu_*) port of the nubus core between NREQ local
// requesters: round-robin grant, locked back-to-back ownership, a mandatory
// idle cycle between unlocked transactions and a watchdog that aborts a
// transaction whose cpu_ready never arrives.
//   nub_clkn/nub_resetn : clock (rising edge) and async active-low reset
//   req_*               : flattened per-requester request buses / responses
//   cpu_*               : master interface toward the nubus core
//   arb_grant/arb_busy  : current owner (one-hot) and non-idle indication
module nubus_master_arbiter
   import nubus_arb_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int TIMEOUT_CLOCKS = 255,
   parameter int CNT_W          = 8
) (
   input  logic                 nub_clkn,
   input  logic                 nub_resetn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [ADDR_W*NREQ-1:0] req_addr,
   input  logic [DATA_W*NREQ-1:0] req_wdata,
   input  logic [BE_W*NREQ-1:0] req_write,
   input  logic [NREQ-1:0]      req_lock,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      req_err,
   output logic [DATA_W-1:0]    req_rdata,
   output logic                 cpu_valid,
   output logic [ADDR_W-1:0]    cpu_addr,
   output logic [DATA_W-1:0]    cpu_wdata,
   output logic [BE_W-1:0]      cpu_write,
   output logic                 cpu_lock,
   input  logic                 cpu_ready,
   input  logic [DATA_W-1:0]    cpu_rdata,
   output logic [NREQ-1:0]      arb_grant,
   output logic                 arb_busy
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam bit WD_EN = (TIMEOUT_CLOCKS != 0);
   // The abort fires on the edge at which the counter would reach TIMEOUT_CLOCKS.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CLOCKS > 0) ? TIMEOUT_CLOCKS - 1 : 0);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
   logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
   logic [BE_W-1:0]   cpu_write_q, cpu_write_d;
   logic              cpu_lock_q, cpu_lock_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              busy_q;
   logic [NREQ-1:0]   ready_q, ready_d;
   logic [NREQ-1:0]   err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [NREQ-1:0]   pick_grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic              issue;
   logic [IDX_W-1:0]  sel_idx;

   logic [ADDR_W-1:0] addr_arr  [NREQ];
   logic [DATA_W-1:0] wdata_arr [NREQ];
   logic [BE_W-1:0]   write_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
         assign write_arr[gi] = req_write[gi*BE_W +: BE_W];
      end
   endgenerate

   nubus_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      cpu_valid_d = cpu_valid_q;
      cpu_addr_d  = cpu_addr_q;
      cpu_wdata_d = cpu_wdata_q;
      cpu_write_d = cpu_write_q;
      cpu_lock_d  = cpu_lock_q;
      grant_d     = grant_q;
      ready_d     = '0;
      err_d       = '0;
      rdata_d     = rdata_q;
      issue       = 1'b0;
      sel_idx     = owner_q;

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               issue   = 1'b1;
               sel_idx = pick_idx;
               ptr_d   = pick_idx;
               owner_d = pick_idx;
               grant_d = pick_grant;
            end
         end
         ARB_GRANT: begin
            cnt_d = cnt_q + 1'b1;
            // cpu_ready has priority over a watchdog expiry on the same edge.
            if (cpu_ready) begin
               rdata_d          = cpu_rdata;
               ready_d[owner_q] = 1'b1;
               cpu_valid_d      = 1'b0;
               if (req_lock[owner_q]) begin
                  cpu_lock_d = 1'b1;
                  state_d    = ARB_LOCKED;
               end else begin
                  cpu_lock_d = 1'b0;
                  grant_d    = '0;
                  state_d    = ARB_GAP;
               end
            end else if (WD_EN && (cnt_q == TO_LAST)) begin
               ready_d[owner_q] = 1'b1;
               err_d[owner_q]   = 1'b1;
               cpu_valid_d      = 1'b0;
               cpu_lock_d       = 1'b0;
               grant_d          = '0;
               state_d          = ARB_GAP;
            end
         end
         ARB_GAP: begin
            state_d = ARB_IDLE;
         end
         ARB_LOCKED: begin
            // Releasing the lock wins over a simultaneous new request; that
            // request is re-arbitrated from IDLE.
            if (!req_lock[owner_q]) begin
               cpu_lock_d = 1'b0;
               grant_d    = '0;
               state_d    = ARB_IDLE;
            end else if (req_valid[owner_q]) begin
               issue = 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (issue) begin
         cpu_valid_d = 1'b1;
         cpu_addr_d  = addr_arr[sel_idx];
         cpu_wdata_d = wdata_arr[sel_idx];
         cpu_write_d = write_arr[sel_idx];
         cpu_lock_d  = req_lock[sel_idx];
         cnt_d       = '0;
         state_d     = ARB_GRANT;
      end
   end

   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state_q     <= ARB_IDLE;
         ptr_q       <= IDX_W'(NREQ - 1);
         owner_q     <= '0;
         cnt_q       <= '0;
         cpu_valid_q <= 1'b0;
         cpu_addr_q  <= '0;
         cpu_wdata_q <= '0;
         cpu_write_q <= '0;
         cpu_lock_q  <= 1'b0;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         ready_q     <= '0;
         err_q       <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         cpu_valid_q <= cpu_valid_d;
         cpu_addr_q  <= cpu_addr_d;
         cpu_wdata_q <= cpu_wdata_d;
         cpu_write_q <= cpu_write_d;
         cpu_lock_q  <= cpu_lock_d;
         grant_q     <= grant_d;
         busy_q      <= (state_d != ARB_IDLE);
         ready_q     <= ready_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign req_ready = ready_q;
   assign req_err   = err_q;
   assign req_rdata = rdata_q;
   assign cpu_valid = cpu_valid_q;
   assign cpu_addr  = cpu_addr_q;
   assign cpu_wdata = cpu_wdata_q;
   assign cpu_write = cpu_write_q;
   assign cpu_lock  = cpu_lock_q;
   assign arb_grant = grant_q;
   assign arb_busy  = busy_q;

endmodule

// File: tb/tb_nubus_master_arbiter.sv
// Bench for nubus_master_arbiter. Instance A (TIMEOUT_CLOCKS=4) is driven by
// a per-requester command driver and a memory model that answers reads with
// ~addr; instance B (TIMEOUT_CLOCKS=2) is driven directly for the
// ready/timeout collision. Completions are checked against expectation queues.
module tb_nubus_master_arbiter;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic        lock;
   } cmd_t;

   typedef struct packed {
      logic [1:0]  who;
      logic        err;
      logic        lock_after;
      logic [31:0] rdata;
   } exp_t;

   logic clk;
   logic rst_n;

   // instance A
   logic [1:0]  a_req_valid, a_req_lock, a_req_ready, a_req_err;
   logic [31:0] a_addr_arr [2];
   logic [31:0] a_wdata_arr [2];
   logic [3:0]  a_we_arr [2];
   logic [63:0] a_req_addr, a_req_wdata;
   logic [7:0]  a_req_write;
   logic [31:0] a_req_rdata, a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
   logic [3:0]  a_cpu_write;
   logic        a_cpu_valid, a_cpu_lock, a_cpu_ready, a_busy;
   logic [1:0]  a_grant;

   // instance B
   logic [1:0]  b_req_valid, b_req_lock, b_req_ready, b_req_err;
   logic [63:0] b_req_addr, b_req_wdata;
   logic [7:0]  b_req_write;
   logic [31:0] b_req_rdata, b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
   logic [3:0]  b_cpu_write;
   logic        b_cpu_valid, b_cpu_lock, b_cpu_ready, b_busy;
   logic [1:0]  b_grant;

   assign a_req_addr  = {a_addr_arr[1], a_addr_arr[0]};
   assign a_req_wdata = {a_wdata_arr[1], a_wdata_arr[0]};
   assign a_req_write = {a_we_arr[1], a_we_arr[0]};

   cmd_t  cmdq0 [$];
   cmd_t  cmdq1 [$];
   exp_t  expa [$];
   exp_t  expb [$];
   logic [1:0] drv_busy;
   logic  drv_flush;
   logic  mem_en;
   int    mem_w;
   int    total;
   int    bad;

   nubus_master_arbiter #(.NREQ(2), .TIMEOUT_CLOCKS(4), .CNT_W(8)) u_dut_a (
      .nub_clkn(clk), .nub_resetn(rst_n),
      .req_valid(a_req_valid), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .req_write(a_req_write), .req_lock(a_req_lock),
      .req_ready(a_req_ready), .req_err(a_req_err), .req_rdata(a_req_rdata),
      .cpu_valid(a_cpu_valid), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_write(a_cpu_write), .cpu_lock(a_cpu_lock),
      .cpu_ready(a_cpu_ready), .cpu_rdata(a_cpu_rdata),
      .arb_grant(a_grant), .arb_busy(a_busy)
   );

   nubus_master_arbiter #(.NREQ(2), .TIMEOUT_CLOCKS(2), .CNT_W(8)) u_dut_b (
      .nub_clkn(clk), .nub_resetn(rst_n),
      .req_valid(b_req_valid), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .req_write(b_req_write), .req_lock(b_req_lock),
      .req_ready(b_req_ready), .req_err(b_req_err), .req_rdata(b_req_rdata),
      .cpu_valid(b_cpu_valid), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_write(b_cpu_write), .cpu_lock(b_cpu_lock),
      .cpu_ready(b_cpu_ready), .cpu_rdata(b_cpu_rdata),
      .arb_grant(b_grant), .arb_busy(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic bit pop_cmd(input bit r, output cmd_t c);
      c = '0;
      if (r == 1'b0) begin
         if (cmdq0.size() == 0) return 1'b0;
         c = cmdq0.pop_front();
      end else begin
         if (cmdq1.size() == 0) return 1'b0;
         c = cmdq1.pop_front();
      end
      return 1'b1;
   endfunction

   task automatic drv_step(input bit r);
      cmd_t c;
      if (drv_busy[r] && a_req_ready[r]) drv_busy[r] = 1'b0;
      if (!drv_busy[r]) begin
         if (pop_cmd(r, c)) begin
            a_req_valid[r] = 1'b1;
            a_addr_arr[r]  = c.addr;
            a_wdata_arr[r] = c.wdata;
            a_we_arr[r]    = c.we;
            a_req_lock[r]  = c.lock;
            drv_busy[r]    = 1'b1;
         end else begin
            a_req_valid[r] = 1'b0;
            a_req_lock[r]  = 1'b0;
         end
      end
   endtask

   // requester driver: holds a command until its req_ready, then moves on
   initial begin
      a_req_valid = '0;
      a_req_lock  = '0;
      drv_busy    = '0;
      for (int i = 0; i < 2; i++) begin
         a_addr_arr[i]  = '0;
         a_wdata_arr[i] = '0;
         a_we_arr[i]    = '0;
      end
      forever begin
         @(negedge clk);
         if (drv_flush) begin
            cmdq0.delete();
            cmdq1.delete();
            drv_busy    = '0;
            a_req_valid = '0;
            a_req_lock  = '0;
         end else begin
            for (int i = 0; i < 2; i++) drv_step(i[0]);
         end
      end
   end

   // memory model: one wait clock, read data = ~addr
   initial begin
      a_cpu_ready = 1'b0;
      a_cpu_rdata = '0;
      mem_w       = 0;
      forever begin
         @(negedge clk);
         if (a_cpu_valid && mem_en && !a_cpu_ready) begin
            if (mem_w >= 1) begin
               a_cpu_ready = 1'b1;
               a_cpu_rdata = ~a_cpu_addr;
               mem_w       = 0;
            end else begin
               mem_w++;
            end
         end else begin
            a_cpu_ready = 1'b0;
            mem_w       = 0;
         end
      end
   end

   // completion monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (a_req_ready != 2'b00 || a_req_err != 2'b00) begin
            if (expa.size() == 0) begin
               check("a_unexpected_ready", 32'(a_req_ready), 32'd0);
            end else begin
               e = expa.pop_front();
               check("a_ready_who", 32'(a_req_ready), 32'(e.who));
               check("a_err", 32'(a_req_err), e.err ? 32'(e.who) : 32'd0);
               if (!e.err) check("a_rdata", a_req_rdata, e.rdata);
               check("a_valid_low_at_done", 32'(a_cpu_valid), 32'd0);
               check("a_grant_at_done", 32'(a_grant), e.lock_after ? 32'(e.who) : 32'd0);
               check("a_lock_at_done", 32'(a_cpu_lock), 32'(e.lock_after));
               $display("A done: who=%b err=%b rdata=%h", a_req_ready, a_req_err, a_req_rdata);
            end
         end
         if (b_req_ready != 2'b00 || b_req_err != 2'b00) begin
            if (expb.size() == 0) begin
               check("b_unexpected_ready", 32'(b_req_ready), 32'd0);
            end else begin
               e = expb.pop_front();
               check("b_ready_who", 32'(b_req_ready), 32'(e.who));
               check("b_err", 32'(b_req_err), e.err ? 32'(e.who) : 32'd0);
               if (!e.err) check("b_rdata", b_req_rdata, e.rdata);
               check("b_valid_low_at_done", 32'(b_cpu_valid), 32'd0);
               $display("B done: who=%b err=%b rdata=%h", b_req_ready, b_req_err, b_req_rdata);
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < 300 && !(expa.size() == 0 && cmdq0.size() == 0 && cmdq1.size() == 0
                              && drv_busy == 2'b00 && !a_busy));
      check(name, 32'(n >= 300), 32'd0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n     = 1'b0;
      drv_flush = 1'b1;
      @(negedge clk);
      @(negedge clk);
      drv_flush = 1'b0;
      rst_n     = 1'b1;
   endtask

   initial begin
      int n;
      int cnt;
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      mem_en = 1'b1;
      drv_flush = 1'b0;
      b_req_valid = '0; b_req_lock = '0; b_req_addr = '0; b_req_wdata = '0; b_req_write = '0;
      b_cpu_ready = 1'b0; b_cpu_rdata = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cpu_valid", 32'(a_cpu_valid), 32'd0);
      check("rst_grant", 32'(a_grant), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_ready", 32'(a_req_ready), 32'd0);
      check("rst_lock", 32'(a_cpu_lock), 32'd0);
      check("rst_b_valid", 32'(b_cpu_valid), 32'd0);
      rst_n = 1'b1;

      // single write from requester 0
      @(posedge clk);
      expa.push_back('{who: 2'b01, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFFF});
      cmdq0.push_back('{addr: 32'hF000_0000, wdata: 32'h8765_4321, we: 4'hF, lock: 1'b0});
      @(negedge clk);
      @(negedge clk);
      check("t1_valid_latency", 32'(a_cpu_valid), 32'd1);
      check("t1_addr", a_cpu_addr, 32'hF000_0000);
      check("t1_wdata", a_cpu_wdata, 32'h8765_4321);
      check("t1_write", 32'(a_cpu_write), 32'hF);
      check("t1_grant", 32'(a_grant), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < 20 && !a_req_ready[0]);
      check("t1_ready_latency", 32'(n), 32'd2);
      check("t1_gap_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      check("t1_idle_busy", 32'(a_busy), 32'd0);
      check("t1_ready_one_cycle", 32'(a_req_ready), 32'd0);
      $display("T1 single write: n=%0d", n);

      // two requesters from reset, requester 0 re-requests
      reset_pulse();
      @(posedge clk);
      expa.push_back('{who: 2'b01, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFFF});
      expa.push_back('{who: 2'b10, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFFB});
      expa.push_back('{who: 2'b01, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFF7});
      cmdq0.push_back('{addr: 32'hF000_0000, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      cmdq0.push_back('{addr: 32'hF000_0008, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      cmdq1.push_back('{addr: 32'hF000_0004, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      @(negedge clk);
      @(negedge clk);
      check("t2_first_grant", 32'(a_grant), 32'd1);
      wait_idle("t2_drain");
      $display("T2 round robin done");

      // locked pair from requester 1 while requester 0 waits
      @(posedge clk);
      expa.push_back('{who: 2'b10, err: 1'b0, lock_after: 1'b1, rdata: 32'h0FFF_FFEF});
      expa.push_back('{who: 2'b10, err: 1'b0, lock_after: 1'b1, rdata: 32'h0FFF_FFEB});
      expa.push_back('{who: 2'b01, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFDF});
      cmdq1.push_back('{addr: 32'hF000_0010, wdata: 32'h0, we: 4'h0, lock: 1'b1});
      cmdq1.push_back('{addr: 32'hF000_0014, wdata: 32'h0, we: 4'h0, lock: 1'b1});
      cmdq0.push_back('{addr: 32'hF000_0020, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      @(negedge clk);
      @(negedge clk);
      check("t3_lock_grant", 32'(a_grant), 32'd2);
      check("t3_cpu_lock", 32'(a_cpu_lock), 32'd1);
      wait_idle("t3_drain");
      $display("T3 locked sequence done");

      // watchdog abort
      mem_en = 1'b0;
      @(posedge clk);
      expa.push_back('{who: 2'b01, err: 1'b1, lock_after: 1'b0, rdata: 32'h0});
      cmdq0.push_back('{addr: 32'hF000_0030, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      @(negedge clk);
      n = 0;
      cnt = 0;
      do begin
         @(negedge clk);
         n++;
         if (a_cpu_valid) cnt++;
      end while (n < 20 && !a_req_ready[0]);
      check("t4_valid_cycles", 32'(cnt), 32'd4);
      check("t4_err", 32'(a_req_err), 32'd1);
      check("t4_gap_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      check("t4_idle_busy", 32'(a_busy), 32'd0);
      mem_en = 1'b1;
      $display("T4 timeout: valid cycles=%0d", cnt);

      // asynchronous reset in the middle of GRANT
      mem_en = 1'b0;
      @(posedge clk);
      cmdq0.push_back('{addr: 32'hF000_0050, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < 20 && !a_cpu_valid);
      #2 rst_n = 1'b0;
      drv_flush = 1'b1;
      #1;
      check("t5_rst_valid", 32'(a_cpu_valid), 32'd0);
      check("t5_rst_grant", 32'(a_grant), 32'd0);
      check("t5_rst_busy", 32'(a_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      drv_flush = 1'b0;
      rst_n = 1'b1;
      mem_en = 1'b1;
      @(posedge clk);
      expa.push_back('{who: 2'b01, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFBF});
      expa.push_back('{who: 2'b10, err: 1'b0, lock_after: 1'b0, rdata: 32'h0FFF_FFBB});
      cmdq0.push_back('{addr: 32'hF000_0040, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      cmdq1.push_back('{addr: 32'hF000_0044, wdata: 32'h0, we: 4'h0, lock: 1'b0});
      @(negedge clk);
      @(negedge clk);
      check("t5_first_grant", 32'(a_grant), 32'd1);
      wait_idle("t5_drain");
      $display("T5 reset mid-grant done");

      // instance B: cpu_ready on the same edge the watchdog would fire
      @(negedge clk);
      expb.push_back('{who: 2'b01, err: 1'b0, lock_after: 1'b0, rdata: 32'hCAFE_F00D});
      b_req_valid = 2'b01;
      b_req_addr  = {32'h0, 32'hF000_0060};
      @(negedge clk);
      check("t6_valid", 32'(b_cpu_valid), 32'd1);
      check("t6_addr", b_cpu_addr, 32'hF000_0060);
      @(negedge clk);
      b_cpu_ready = 1'b1;
      b_cpu_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      b_cpu_ready = 1'b0;
      b_req_valid = 2'b00;
      check("t6_ready", 32'(b_req_ready), 32'd1);
      repeat (2) @(negedge clk);

      // instance B: plain timeout after two edges
      expb.push_back('{who: 2'b01, err: 1'b1, lock_after: 1'b0, rdata: 32'h0});
      b_req_valid = 2'b01;
      b_req_addr  = {32'h0, 32'hF000_0070};
      n = 0;
      cnt = 0;
      do begin
         @(negedge clk);
         n++;
         if (b_cpu_valid) cnt++;
      end while (n < 20 && !b_req_ready[0]);
      b_req_valid = 2'b00;
      check("t6_b_timeout_cycles", 32'(cnt), 32'd2);
      repeat (3) @(negedge clk);
      check("end_expa_empty", 32'(expa.size()), 32'd0);
      check("end_expb_empty", 32'(expb.size()), 32'd0);
      $display("T6 ready/timeout collision done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
